// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//   XLEN / CACHE_LINES : address width and number of 8-byte lines
//   IDX_W / TAG_W      : derived line index and tag widths
//   BUS_COMMAND        : memory bus command encoding
//   ICACHE_STATE       : miss-handling FSM states
//   ICACHE_LINE        : one cache line {valid, tag, data}
package icache_pkg;

    localparam int XLEN        = 32;
    localparam int CACHE_LINES = 32;
    localparam int IDX_W       = $clog2(CACHE_LINES);
    localparam int TAG_W       = XLEN - 3 - IDX_W;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        IDLE  = 2'h0,
        ISSUE = 2'h1,
        WAIT  = 2'h2
    } ICACHE_STATE;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } ICACHE_LINE;

endpackage

// File: rtl/icache_mem.sv
// Line storage for the direct-mapped instruction cache.
//   clk        in   clock
//   rst_ni     in   synchronous active-low clear of every valid bit
//   rd_idx_i   in   combinational read index
//   rd_line_o  out  line at rd_idx_i (pre-write contents on a same-cycle write)
//   we_i       in   write enable
//   wr_idx_i   in   write index
//   wr_line_i  in   line written on the next rising edge
module icache_mem
    import icache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output ICACHE_LINE       rd_line_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  ICACHE_LINE       wr_line_i
);

    ICACHE_LINE lines_q [CACHE_LINES];

    assign rd_line_o = lines_q[rd_idx_i];

    // Only the valid bits are cleared; tag/data contents are don't-care
    // until a fill sets the valid bit again.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < CACHE_LINES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else if (we_i) begin
            lines_q[wr_idx_i] <= wr_line_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache in front of fetch.
//   clk / reset          clock, synchronous active-low reset
//   proc2Icache_addr     fetch block address (bits [2:0] ignored)
//   read_valid_i         new request; replaces any pending request
//   Icache_data_o        64-bit block for the pending request
//   Icache_valid_o       one-cycle pulse qualifying Icache_data_o
//   proc2Imem_command    BUS_NONE / BUS_LOAD
//   proc2Imem_addr       8-byte aligned miss address
//   Imem2proc_response   nonzero = load accepted, value is its tag
//   Imem2proc_data       fill data
//   Imem2proc_tag        tag of returning data, 0 = none
module icache
    import icache_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    input  logic            read_valid_i,
    output logic [63:0]     Icache_data_o,
    output logic            Icache_valid_o,
    output logic [1:0]      proc2Imem_command,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic [3:0]      Imem2proc_response,
    input  logic [63:0]     Imem2proc_data,
    input  logic [3:0]      Imem2proc_tag
);

    localparam logic [XLEN-1:0] ADDR_MASK = {{(XLEN-3){1'b1}}, 3'b000};

    ICACHE_STATE     state_q;
    logic            pending_q;
    logic [3:0]      exp_tag_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] fill_addr_q;

    ICACHE_LINE rd_line;
    ICACHE_LINE wr_line;
    logic       lookup_hit;
    logic       fill_done;
    logic       bypass;
    logic       issuing;

    icache_mem u_mem (
        .clk       (clk),
        .rst_ni    (reset),
        .rd_idx_i  (req_addr_q[3 +: IDX_W]),
        .rd_line_o (rd_line),
        .we_i      (fill_done),
        .wr_idx_i  (fill_addr_q[3 +: IDX_W]),
        .wr_line_i (wr_line)
    );

    // Lookups are suppressed while a fill is outstanding; a redirect made
    // during WAIT is looked up once the FSM is back in IDLE.
    assign lookup_hit = pending_q && (state_q != WAIT) && rd_line.valid &&
                        (rd_line.tag == req_addr_q[XLEN-1 -: TAG_W]);

    assign fill_done  = (state_q == WAIT) && (Imem2proc_tag != 4'd0) &&
                        (Imem2proc_tag == exp_tag_q);

    // A request arriving with the fill takes priority; if it names the
    // filled block it hits from the array on the following cycle instead.
    assign bypass     = fill_done && pending_q && !read_valid_i &&
                        (req_addr_q == fill_addr_q);

    // In ISSUE a retargeted request that hits must not reach the bus.
    assign issuing    = (state_q == ISSUE) && !lookup_hit;

    assign wr_line = '{valid: 1'b1,
                       tag:   fill_addr_q[XLEN-1 -: TAG_W],
                       data:  Imem2proc_data};

    assign Icache_valid_o    = lookup_hit || bypass;
    assign Icache_data_o     = bypass     ? Imem2proc_data :
                               lookup_hit ? rd_line.data   : 64'd0;
    assign proc2Imem_command = issuing ? BUS_LOAD : BUS_NONE;
    assign proc2Imem_addr    = issuing ? req_addr_q : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            exp_tag_q   <= 4'd0;
            req_addr_q  <= '0;
            fill_addr_q <= '0;
        end else begin
            if (read_valid_i) begin
                req_addr_q <= proc2Icache_addr & ADDR_MASK;
                pending_q  <= 1'b1;
            end else if (Icache_valid_o) begin
                pending_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pending_q && !lookup_hit) state_q <= ISSUE;
                end
                ISSUE: begin
                    if (lookup_hit || !pending_q) begin
                        state_q <= IDLE;
                    end else if (Imem2proc_response != 4'd0) begin
                        exp_tag_q   <= Imem2proc_response;
                        fill_addr_q <= req_addr_q;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (fill_done) begin
                        exp_tag_q <= 4'd0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: expected fetch responses are queued as the
// stimulus is issued and a negedge monitor pops and compares them on every
// Icache_valid_o pulse; bus activity is counted by the same monitor.
module tb_icache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] proc2Icache_addr;
    logic        read_valid_i;
    logic [63:0] Icache_data_o;
    logic        Icache_valid_o;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cycles = 0;
    int load_accepts = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    icache dut (
        .clk                (clk),
        .reset              (reset),
        .proc2Icache_addr   (proc2Icache_addr),
        .read_valid_i       (read_valid_i),
        .Icache_data_o      (Icache_data_o),
        .Icache_valid_o     (Icache_valid_o),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued response.
    always @(negedge clk) begin
        if (reset === 1'b1 && proc2Imem_command === BUS_LOAD) begin
            load_cycles++;
            if (Imem2proc_response != 4'd0) load_accepts++;
        end
        if (Icache_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_data", Icache_data_o, 64'hx);
            end else begin
                chk("resp_data", Icache_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a);
        read_valid_i     = 1'b1;
        proc2Icache_addr = a;
        cyc();
        read_valid_i     = 1'b0;
    endtask

    task automatic wait_load(input logic [31:0] a);
        int n = 0;
        while (proc2Imem_command !== BUS_LOAD && n < 20) begin
            cyc();
            n++;
        end
        chk("load_seen", 64'(proc2Imem_command), 64'(BUS_LOAD));
        chk("load_addr", 64'(proc2Imem_addr), 64'(a));
    endtask

    task automatic serve_load(input logic [31:0] a, input int nretry, input logic [3:0] t);
        wait_load(a);
        for (int i = 0; i < nretry; i++) begin
            Imem2proc_response = 4'd0;
            cyc();
            chk("retry_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
            chk("retry_addr", 64'(proc2Imem_addr), 64'(a));
        end
        Imem2proc_response = t;
        cyc();
        Imem2proc_response = 4'd0;
    endtask

    task automatic ret_fill(input int delay, input logic [3:0] t, input logic [63:0] d);
        repeat (delay) cyc();
        Imem2proc_tag  = t;
        Imem2proc_data = d;
        cyc();
        Imem2proc_tag  = 4'd0;
        Imem2proc_data = 64'd0;
    endtask

    task automatic drained(input string name);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_valid"}, 64'(Icache_valid_o), 64'd0);
        chk({name, "_cmd"},   64'(proc2Imem_command), 64'(BUS_NONE));
        chk({name, "_addr"},  64'(proc2Imem_addr), 64'd0);
        chk({name, "_data"},  Icache_data_o, 64'd0);
    endtask

    initial begin
        int lc0;
        int la0;
        reset              = 1'b0;
        read_valid_i       = 1'b0;
        proc2Icache_addr   = 32'd0;
        Imem2proc_response = 4'd0;
        Imem2proc_data     = 64'd0;
        Imem2proc_tag      = 4'd0;

        // Reset held for 3 cycles
        repeat (3) cyc();
        chk_idle_outputs("reset");
        reset = 1'b1;
        cyc();
        chk_idle_outputs("post_reset");

        // Cold miss: 0x104 -> load at 0x100, response after 2 retries, fill 6 later
        la0 = load_accepts;
        exp_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        req(32'h0000_0104);
        serve_load(32'h100, 2, 4'd3);
        ret_fill(6, 4'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        drained("cold_bypass");
        chk("cold_one_load", 64'(load_accepts - la0), 64'd1);

        // Hit on 0x100: next-cycle pulse, no bus activity
        lc0 = load_cycles;
        exp_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        req(32'h100);
        cyc();
        cyc();
        drained("hit_100");
        chk("hit_no_bus", 64'(load_cycles - lc0), 64'd0);

        // Conflict: 0x2100 replaces line 0, then 0x100 misses again
        exp_q.push_back(64'h2100_2100_2100_2100);
        req(32'h2100);
        serve_load(32'h2100, 0, 4'd4);
        ret_fill(2, 4'd4, 64'h2100_2100_2100_2100);
        drained("conflict_fill");
        exp_q.push_back(64'h1111_2222_3333_4444);
        req(32'h100);
        serve_load(32'h100, 0, 4'd6);
        ret_fill(0, 4'd6, 64'h1111_2222_3333_4444);
        drained("refill_100");

        // Redirect in WAIT: no pulse for stale 0x200, then load 0x300;
        // 0x200 requested during that ISSUE hits and cancels the load
        req(32'h200);
        serve_load(32'h200, 0, 4'd5);
        req(32'h300);
        ret_fill(1, 4'd5, 64'h5555_0000_0000_0200);
        drained("redirect_no_pulse");
        wait_load(32'h300);
        exp_q.push_back(64'h5555_0000_0000_0200);
        req(32'h200);
        chk("issue_hit_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
        cyc();
        drained("redirect_later_hit");

        // Retry: load held 5 cycles, then retargeted to 0x400
        req(32'h600);
        wait_load(32'h600);
        lc0 = load_cycles;
        la0 = load_accepts;
        for (int i = 0; i < 4; i++) begin
            Imem2proc_response = 4'd0;
            cyc();
            chk("retry_hold", 64'(proc2Imem_addr), 64'h600);
        end
        req(32'h400);
        chk("retarget_addr", 64'(proc2Imem_addr), 64'h400);
        Imem2proc_response = 4'd7;
        cyc();
        Imem2proc_response = 4'd0;
        chk("retry_load_cycles", 64'(load_cycles - lc0), 64'd6);
        chk("retry_one_accept", 64'(load_accepts - la0), 64'd1);
        exp_q.push_back(64'h4444_0000_0000_0400);
        ret_fill(1, 4'd7, 64'h4444_0000_0000_0400);
        drained("retry_fill");

        // Stray tag 7 while waiting on tag 2 is ignored
        req(32'h808);
        serve_load(32'h808, 0, 4'd2);
        ret_fill(1, 4'd7, 64'hDEAD_DEAD_DEAD_DEAD);
        chk("stray_still_wait", 64'(proc2Imem_command), 64'(BUS_NONE));
        drained("stray_no_pulse");
        exp_q.push_back(64'h8888_0000_0000_0808);
        ret_fill(2, 4'd2, 64'h8888_0000_0000_0808);
        drained("stray_real_fill");
        exp_q.push_back(64'h8888_0000_0000_0808);
        req(32'h808);
        cyc();
        drained("hit_808");

        // Request on the fill cycle to the same block: no bypass, hit next cycle
        req(32'h900);
        serve_load(32'h900, 0, 4'd3);
        exp_q.push_back(64'h9999_0000_0000_0900);
        cyc();
        Imem2proc_tag    = 4'd3;
        Imem2proc_data   = 64'h9999_0000_0000_0900;
        read_valid_i     = 1'b1;
        proc2Icache_addr = 32'h904;
        cyc();
        Imem2proc_tag    = 4'd0;
        Imem2proc_data   = 64'd0;
        read_valid_i     = 1'b0;
        chk("same_cycle_hit_valid", 64'(Icache_valid_o), 64'd1);
        cyc();
        drained("same_cycle_fill");

        // Reset during WAIT: late tag ignored, array cleared
        req(32'hA08);
        serve_load(32'hA08, 0, 4'd4);
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        chk_idle_outputs("mid_reset");
        ret_fill(1, 4'd4, 64'hAAAA_0000_0000_0A08);
        drained("late_tag_no_pulse");
        req(32'h808);
        wait_load(32'h808);
        req(32'hA08);
        wait_load(32'hA08);
        drained("after_reset_misses");

        reset = 1'b0;
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
